// File: rtl/gene_stream_reader.sv
// rtl/gene_stream_reader.sv - walks one genome (nodes, then connections) into a stallable gene stream
// Optional: GENE_STREAM_DROP_DISABLED_EN turns disabled connection genes into bubbles.
module gene_stream_reader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [63:0] TERM_GENE  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] NodeCount,
  input  logic [ADDR_WIDTH-1:0] ConnBase,
  input  logic [ADDR_WIDTH-1:0] ConnCount,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRd,
  input  logic [63:0]           MemData,
  input  logic                  Stall,
  output logic [63:0]           OutGene,
  output logic                  OutValid,
  output logic                  Busy,
  output logic                  Done,
  output logic [7:0]            MaxNodeID
);

  typedef enum logic [2:0] {S_IDLE, S_NODES, S_CONNS, S_DRAIN, S_TERM} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] node_cnt_q, node_cnt_d;
  logic [ADDR_WIDTH-1:0] conn_cnt_q, conn_cnt_d;
  logic [ADDR_WIDTH-1:0] conn_base_q, conn_base_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  rd_pend_q;
  logic                  skid_vld_q, skid_vld_d;
  logic [63:0]           skid_q, skid_d;
  logic [63:0]           gene_q, gene_d;
  logic                  vld_q, vld_d;
  logic [7:0]            max_q, max_d;
  logic                  issue_ok;
  logic                  keep_rd;

  // A read may only issue when its data is guaranteed a home: output free and skid empty.
  assign issue_ok = !Stall && !skid_vld_q;

  always_comb begin
    keep_rd = rd_pend_q;
`ifdef GENE_STREAM_DROP_DISABLED_EN
    if (MemData[55] && !MemData[54]) keep_rd = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    node_cnt_d  = node_cnt_q;
    conn_cnt_d  = conn_cnt_q;
    conn_base_d = conn_base_q;
    idx_d       = idx_q;
    skid_vld_d  = skid_vld_q;
    skid_d      = skid_q;
    gene_d      = gene_q;
    vld_d       = vld_q;
    max_d       = max_q;
    MemRd       = 1'b0;
    MemAddr     = '0;
    Done        = 1'b0;

    if (!Stall && vld_q && !gene_q[55] && gene_q[63:56] != 8'hFF && gene_q[47:40] >= max_q)
      max_d = gene_q[47:40];

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          node_cnt_d  = NodeCount;
          conn_cnt_d  = ConnCount;
          conn_base_d = ConnBase;
          idx_d       = '0;
          max_d       = '0;
          if (NodeCount != '0)      state_d = S_NODES;
          else if (ConnCount != '0) state_d = S_CONNS;
          else                      state_d = S_DRAIN;
        end
      end
      S_NODES: begin
        MemAddr = idx_q;
        MemRd   = issue_ok;
        if (issue_ok) begin
          if (idx_q + ONE == node_cnt_q) begin
            idx_d   = '0;
            state_d = (conn_cnt_q != '0) ? S_CONNS : S_DRAIN;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      S_CONNS: begin
        MemAddr = conn_base_q + idx_q;
        MemRd   = issue_ok;
        if (issue_ok) begin
          if (idx_q + ONE == conn_cnt_q) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (!Stall && !skid_vld_q && !rd_pend_q) state_d = S_TERM;
      end
      S_TERM: begin
        if (!Stall) begin
          Done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output register: skid entry first, then returning read, else terminator or bubble.
    if (!Stall) begin
      if (skid_vld_q) begin
        gene_d     = skid_q;
        vld_d      = 1'b1;
        skid_vld_d = 1'b0;
      end else if (keep_rd) begin
        gene_d = MemData;
        vld_d  = 1'b1;
      end else if (state_q == S_DRAIN && state_d == S_TERM) begin
        gene_d = TERM_GENE;
        vld_d  = 1'b1;
      end else begin
        gene_d = TERM_GENE;
        vld_d  = 1'b0;
      end
    end else if (keep_rd) begin
      skid_d     = MemData;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      node_cnt_q  <= '0;
      conn_cnt_q  <= '0;
      conn_base_q <= '0;
      idx_q       <= '0;
      rd_pend_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_q      <= TERM_GENE;
      gene_q      <= TERM_GENE;
      vld_q       <= 1'b0;
      max_q       <= '0;
    end else begin
      state_q     <= state_d;
      node_cnt_q  <= node_cnt_d;
      conn_cnt_q  <= conn_cnt_d;
      conn_base_q <= conn_base_d;
      idx_q       <= idx_d;
      rd_pend_q   <= MemRd;
      skid_vld_q  <= skid_vld_d;
      skid_q      <= skid_d;
      gene_q      <= gene_d;
      vld_q       <= vld_d;
      max_q       <= max_d;
    end
  end

  assign OutGene   = gene_q;
  assign OutValid  = vld_q;
  assign Busy      = (state_q != S_IDLE);
  assign MaxNodeID = max_q;

endmodule

// File: tb/tb_gene_stream_reader.sv
// tb/tb_gene_stream_reader.sv - gene_stream_reader bench: queue-based stream model, per-cycle compare
module tb_gene_stream_reader;

  localparam logic [63:0] TERM = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef GENE_STREAM_DROP_DISABLED_EN
  localparam int T1_ACC = 5;
`else
  localparam int T1_ACC = 6;
`endif

  logic        clk = 1'b0;
  logic        Reset, Start, Stall;
  logic [7:0]  NodeCount, ConnBase, ConnCount, MemAddr;
  logic        MemRd;
  logic [63:0] MemData;
  logic [63:0] OutGene;
  logic        OutValid, Busy, Done;
  logic [7:0]  MaxNodeID;

  gene_stream_reader dut (
    .clk(clk), .Reset(Reset), .Start(Start),
    .NodeCount(NodeCount), .ConnBase(ConnBase), .ConnCount(ConnCount),
    .MemAddr(MemAddr), .MemRd(MemRd), .MemData(MemData), .Stall(Stall),
    .OutGene(OutGene), .OutValid(OutValid), .Busy(Busy), .Done(Done),
    .MaxNodeID(MaxNodeID)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [256];
  always @(posedge clk) if (MemRd) MemData <= mem[MemAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] mk(bit conn, bit en, logic [7:0] id, logic [7:0] dst, logic [31:0] w);
    return {8'h00, conn, en, 6'h00, id, dst, w};
  endfunction

  function automatic bit shown(logic [63:0] g);
`ifdef GENE_STREAM_DROP_DISABLED_EN
    return !(g[55] && !g[54]);
`else
    return (g[63:56] != 8'hFF) || 1'b1;
`endif
  endfunction

  logic [7:0]  q_addr[$];
  logic [63:0] q_gene[$];
  logic [7:0]  exp_max;
  bit          mon_en = 0, busy_exp = 0, done_seen = 0, prev_stall = 0, prev_valid = 0, exp_done;
  logic [63:0] prev_gene, mon_g;
  logic [7:0]  mon_a, last_addr;
  int          rd_cnt, acc_cnt, first_rd, last_rd, first_val, done_cyc, start_cyc;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(Busy), 64'(busy_exp));
      if (MemRd) begin
        chk("rd_gated_by_stall", 64'(Stall), 64'd0);
        if (rd_cnt == 0) first_rd = cyc;
        last_rd   = cyc;
        last_addr = MemAddr;
        rd_cnt++;
        if (q_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_read: actual addr %0h required no read", MemAddr);
        end else begin
          mon_a = q_addr.pop_front();
          chk("mem_addr", 64'(MemAddr), 64'(mon_a));
        end
      end
      if (!OutValid) chk("bubble_gene", OutGene, TERM);
      if (prev_stall) begin
        chk("hold_gene", OutGene, prev_gene);
        chk("hold_valid", 64'(OutValid), 64'(prev_valid));
      end
      exp_done = 1'b0;
      if (OutValid && !Stall) begin
        if (acc_cnt == 0) first_val = cyc;
        acc_cnt++;
        if (q_gene.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_gene: actual %0h required none", OutGene);
        end else begin
          exp_done = (q_gene.size() == 1);
          mon_g = q_gene.pop_front();
          chk("out_gene", OutGene, mon_g);
        end
      end
      chk("done", 64'(Done), 64'(exp_done));
      if (exp_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (exp_done)               busy_exp = 1'b0;
      else if (!busy_exp && Start) busy_exp = 1'b1;
      prev_stall = Stall;
      prev_gene  = OutGene;
      prev_valid = OutValid;
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_addr"},  64'(MemAddr),   64'd0);
    chk({p, "_rd"},    64'(MemRd),     64'd0);
    chk({p, "_gene"},  OutGene,        TERM);
    chk({p, "_valid"}, 64'(OutValid),  64'd0);
    chk({p, "_busy"},  64'(Busy),      64'd0);
    chk({p, "_done"},  64'(Done),      64'd0);
    chk({p, "_max"},   64'(MaxNodeID), 64'd0);
  endtask

  // mode 0: no stall, 1: 4-cycle stall after first read, 2: random stall and stray Start
  task automatic run_genome(input int nc, input int cb, input int cc, input int mode);
    logic [63:0] g;
    logic [7:0]  a;
    int          st_n = 0;
    bit          st_chk = 0, ok = 0;
    q_addr.delete(); q_gene.delete(); exp_max = 8'h00;
    for (int i = 0; i < nc + cc; i++) begin
      a = (i < nc) ? 8'(i) : 8'((cb + i - nc) % 256);
      g = mem[a];
      q_addr.push_back(a);
      if (shown(g)) q_gene.push_back(g);
      if (!g[55] && g[47:40] > exp_max) exp_max = g[47:40];
    end
    q_gene.push_back(TERM);
    rd_cnt = 0; acc_cnt = 0; done_seen = 0; prev_stall = 0; first_rd = 0; first_val = 0;
    tick();
    NodeCount = 8'(nc); ConnBase = 8'(cb); ConnCount = 8'(cc); Start = 1'b1;
    Stall = (mode == 2) && ($urandom_range(0, 2) == 0);
    start_cyc = cyc;
    mon_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (done_seen) begin ok = 1; break; end
      Start = (mode == 2) && ($urandom_range(0, 3) == 0);
      if (mode == 1) begin
        if (rd_cnt > 0 && st_n < 4) begin
          Stall = 1'b1; st_n++;
        end else begin
          if (st_n == 4 && !st_chk) begin
            chk("reads_before_release", 64'(rd_cnt), 64'd1);
            st_chk = 1;
          end
          Stall = 1'b0;
        end
      end else begin
        Stall = (mode == 2) && ($urandom_range(0, 2) == 0);
      end
    end
    Start = 1'b0; Stall = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout: actual %0d genes outstanding required terminator within 600 cycles", q_gene.size());
    end
    tick(); tick();
    mon_en = 1'b0;
    chk("addr_queue_left", 64'(q_addr.size()), 64'd0);
    chk("gene_queue_left", 64'(q_gene.size()), 64'd0);
    chk("max_node_id", 64'(MaxNodeID), 64'(exp_max));
    if (!ok) begin
      Reset = 1'b1; tick(); Reset = 1'b0; busy_exp = 1'b0;
    end
  endtask

  task automatic load_t1();
    mem[0]  = mk(0, 0, 8'h03, 8'h00, 32'h1111_0000);
    mem[1]  = mk(0, 0, 8'h07, 8'h00, 32'h2222_0000);
    mem[8]  = mk(1, 1, 8'h03, 8'h07, 32'h3333_0001);
    mem[9]  = mk(1, 0, 8'h07, 8'h03, 32'h4444_0002);
    mem[10] = mk(1, 1, 8'h03, 8'h03, 32'h5555_0003);
  endtask

  bit found;
  initial begin
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0;
    NodeCount = 8'h00; ConnBase = 8'h00; ConnCount = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    repeat (3) tick();
    Reset = 1'b0;
    @(negedge clk);
    chk_reset("reset");

    load_t1();
    run_genome(2, 8, 3, 0);
    chk("t1_latency",  64'(first_val - first_rd), 64'd2);
    chk("t1_rd_span",  64'(last_rd - first_rd),   64'd4);
    chk("t1_rd_cnt",   64'(rd_cnt),               64'd5);
    chk("t1_accepted", 64'(acc_cnt),              64'(T1_ACC));
    chk("t1_done_slot",64'(done_cyc - first_val), 64'd5);
    chk("t1_max_lit",  64'(MaxNodeID),            64'h07);

    run_genome(0, 0, 0, 0);
    chk("empty_rd_cnt",   64'(rd_cnt), 64'd0);
    chk("empty_done_lat", 64'((done_cyc - start_cyc) <= 3), 64'd1);
    chk("empty_busy",     64'(Busy), 64'd0);

    run_genome(2, 8, 3, 1);
    chk("stall_accepted", 64'(acc_cnt), 64'(T1_ACC));

    mem[254] = mk(1, 1, 8'h10, 8'h11, 32'hAAAA_0000);
    mem[255] = mk(1, 1, 8'h12, 8'h13, 32'hBBBB_0000);
    mem[0]   = mk(1, 1, 8'h14, 8'h15, 32'hCCCC_0000);
    run_genome(0, 254, 3, 0);
    chk("wrap_rd_cnt",    64'(rd_cnt),    64'd3);
    chk("wrap_last_addr", 64'(last_addr), 64'h00);

    load_t1();
    tick();
    NodeCount = 8'd2; ConnBase = 8'd8; ConnCount = 8'd3; Start = 1'b1; Stall = 1'b0;
    tick();
    Start = 1'b0;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (MemRd && MemAddr == 8'd8) begin found = 1; break; end
    end
    chk("mid_conns_reached", 64'(found), 64'd1);
    @(posedge clk); #1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge clk);
    chk_reset("mid_reset");
    busy_exp = 1'b0;
    run_genome(2, 8, 3, 0);
    chk("after_reset_max", 64'(MaxNodeID), 64'h07);

    for (int r = 0; r < 25; r++) begin
      int nc, cc, cb;
      nc = $urandom_range(0, 6);
      cc = $urandom_range(0, 6);
      cb = (nc + $urandom_range(0, 255)) % 256;
      for (int i = 0; i < nc; i++)
        mem[i] = mk(0, 1'($urandom), 8'($urandom), 8'($urandom), $urandom);
      for (int i = 0; i < cc; i++)
        mem[(cb + i) % 256] = mk(1, 1'($urandom), 8'($urandom), 8'($urandom), $urandom);
      run_genome(nc, cb, cc, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gene_stream_reader.md
Name: gene_stream_reader

Overview:
- Upstream feeder for the add-gene/mutation engines.
- Walks one genome held in a synchronous-read gene memory: node genes first, then connection genes. Presents them as a registered 64-bit gene stream with a downstream stall input.
- Closes each genome with an all-ones terminator gene.
- Tracks the maximum node ID seen, so downstream stages start their new-node numbering from a correct value.

Parameters:
- ADDR_WIDTH, 8, gene memory address width; also the width of the count/base inputs.
- TERM_GENE, 64'hFFFFFFFFFFFFFFFF, terminator/idle gene value.

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin streaming one genome; sampled only in IDLE
- NodeCount  in  ADDR_WIDTH  number of node genes, stored at addresses 0..NodeCount-1
- ConnBase  in  ADDR_WIDTH  address of first connection gene
- ConnCount  in  ADDR_WIDTH  number of connection genes
- MemAddr  out  ADDR_WIDTH  gene memory read address
- MemRd  out  1  read strobe; MemData valid exactly one cycle later
- MemData  in  64  gene memory read data
- Stall  in  1  downstream not accepting; OutGene/OutValid hold while high
- OutGene  out  64  current gene
- OutValid  out  1  OutGene holds a real gene or the terminator
- Busy  out  1  high from Start acceptance until terminator accepted
- Done  out  1  one-cycle pulse when terminator is accepted (Stall low)
- MaxNodeID  out  8  max of bits [47:40] over emitted node genes

Behaviour:
- Gene fields: [63:56] all ones = idle/terminator; [55] 1 = connection, 0 = node; [54] connection enable; [47:40] node ID / source; [39:32] destination; [31:0] weight/value.
- Reset values:
  - MemAddr 0, MemRd 0
  - OutGene TERM_GENE, OutValid 0
  - Busy 0, Done 0, MaxNodeID 0
  - skid buffer empty; state IDLE
- Reset mid-operation: the in-flight read is discarded; next cycle returns to the reset state.
- States: IDLE, NODES, CONNS, DRAIN, TERM.
- IDLE + Start:
  - Latches counts and ConnBase; clears MaxNodeID; sets Busy.
  - Goes to NODES, or to CONNS if NodeCount=0, or to DRAIN if both counts are 0.
  - Start is ignored while Busy.
- NODES: issues reads at addresses 0..NodeCount-1. After the last issue, goes to CONNS (or DRAIN if ConnCount=0).
- CONNS: issues reads at ConnBase+i for i=0..ConnCount-1. Address arithmetic is mod 2^ADDR_WIDTH (wrap allowed). After the last issue, goes to DRAIN.
- Read issue: MemRd=1 in NODES/CONNS only when Stall=0 and the skid buffer is empty. One read per cycle maximum.
- Latency: read issued at cycle t gives MemData at t+1 and OutGene/OutValid at t+2 when Stall is low throughout. Back-to-back throughput is one gene per cycle.
- Stall:
  - While Stall=1, OutGene/OutValid hold.
  - A read returning during Stall is captured in a 1-entry skid buffer.
  - On Stall deassertion, the skid entry goes out first, then the normal flow resumes. No gene is lost or duplicated.
- Bubbles: OutValid=0 on cycles with no gene to present; OutGene=TERM_GENE then.
- DRAIN: waits until the last read has been delivered and the skid buffer is empty, then goes to TERM.
- TERM:
  - Drives OutGene=TERM_GENE, OutValid=1 until a cycle with Stall=0.
  - In that cycle Done=1. Next cycle: Busy=0, OutValid=0, state IDLE.
- MaxNodeID: updated with a >= compare as each node gene is presented with Stall=0. It stays stable after Done until the next accepted Start.
- Simultaneous Start and Reset: Reset wins.

Optional Feature:
- Macro: GENE_STREAM_DROP_DISABLED_EN.
- Defined: connection genes with bit [54]=0 are not presented. Their slot becomes a bubble (OutValid=0) and they never enter the skid buffer. Node genes and the terminator are unaffected.
- Undefined: every gene read is presented unchanged.

Test Plan:
- NodeCount=2, ConnCount=3, ConnBase=8, Stall=0, memory holds distinct genes:
  - MemAddr sequence 0,1,8,9,10 on consecutive cycles.
  - OutGene emits the five genes in that order starting 2 cycles after the first MemRd, then TERM_GENE with OutValid=1 and Done=1 in the same cycle.
  - Node IDs 0x03 and 0x07 give MaxNodeID=0x07.
- NodeCount=0, ConnCount=0, Start pulse: no MemRd ever asserted; terminator presented with Done=1 within 3 cycles; Busy then 0.
- Same setup as the first case, Stall held high for 4 cycles starting the cycle after the first MemRd:
  - OutGene holds; exactly one extra gene sits in the skid buffer.
  - After release, the output order is unchanged and there are no duplicates.
- ConnBase=0xFE, ConnCount=3 on 8-bit addresses: connection reads at 0xFE, 0xFF, 0x00.
- Reset asserted mid-CONNS with a read in flight: next cycle all outputs are at reset values. A following Start streams the genome from address 0 correctly.
- GENE_STREAM_DROP_DISABLED_EN defined, 3 connections with bit 54 = 1,0,1: only the first and third are presented; a bubble appears in the middle slot; the terminator follows.
